sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-to-parallel deserializer that sits directly downstream of the single-bit registered data stage (`dff`). It consumes the registered serial bit `q` from that flop and assembles `WIDTH`-bit words. Completed words are presented on a one-entry output register with a valid/ready handshake. Words that cannot be accepted are counted as overflow.

## Interface

Parameters:
- `WIDTH`, default 8: word width in bits; legal values are ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first received bit becomes `dout[WIDTH-1]`; 0 means the first received bit becomes `dout[0]`.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  serial data bit, driven by the upstream flop output `q`.
- `din_vld`  in  1  `din` is sampled on this posedge.
- `sof`  in  1  start of frame; meaningful only when `din_vld`=1. The current bit is bit 0 of a new word.
- `dout`  out  WIDTH  assembled word.
- `dout_vld`  out  1  `dout` holds an unconsumed word.
- `dout_rdy`  in  1  consumer accepts `dout` on this posedge when `dout_vld`=1.
- `ovf`  out  1  sticky overflow; a completed word was dropped.
- `bit_cnt`  out  $clog2(WIDTH)  number of bits held in the partial word.

## Operation

Shift register `sh[WIDTH-1:0]` and counter `cnt` run on each posedge with `din_vld`=1:
- `MSB_FIRST`=1: `sh <= {sh[WIDTH-2:0], din}`.
- `MSB_FIRST`=0: `sh <= {din, sh[WIDTH-1:1]}`.
- If `sof`=1, the bit is treated as bit 0:
  - the partial word is discarded;
  - the discard does not set `ovf`;
  - `cnt` becomes 1.
- Otherwise `cnt` increments.
- A word completes when the accepted bit is bit `WIDTH-1`. The completed value is the shifted value including `din`. `cnt` wraps to 0.
- With `din_vld`=0, `sh` and `cnt` hold.

Output FSM, two states:
- EMPTY (`dout_vld`=0):
  - A completed word loads `dout` and moves to FULL.
- FULL (`dout_vld`=1):
  - `dout_rdy`=1 and no completed word: move to EMPTY. `dout` holds its last value.
  - `dout_rdy`=1 and a completed word in the same cycle: load the new word and stay in FULL. `ovf` is not set.
  - `dout_rdy`=0 and a completed word: drop the new word, set `ovf`=1, and leave `dout` unchanged.
  - `dout_rdy`=0 and no completed word: hold.

Other rules:
- `ovf` clears only on `rst`.
- `bit_cnt` = `cnt`.

## Timing

- Reset values, applied at the posedge where `rst`=1:
  - `sh` = 0
  - `cnt` = 0
  - `dout` = 0
  - `dout_vld` = 0
  - `ovf` = 0
  - `bit_cnt` = 0
- `rst` has priority over all inputs. Reset mid-word discards the partial bits.
- Latency: `dout_vld` rises on the posedge that samples the last bit of a word. It is visible in the same cycle as that edge and was not present before it.
- Minimum word period is `WIDTH` cycles. Gaps in `din_vld` stretch the period arbitrarily.
- `dout` is stable while `dout_vld`=1 and `dout_rdy`=0.
- A transfer completes on a posedge with `dout_vld`=1 and `dout_rdy`=1.
- `dout_rdy` is ignored when `dout_vld`=0.
- No combinational path from any input to any output.
- Throughput: with `dout_rdy` tied to 1, back-to-back words never set `ovf`.

## Test plan

- **Basic word:** reset, then `WIDTH`=8, `MSB_FIRST`=1, `dout_rdy`=1.
  - Stimulus: bits 1,0,1,0,0,1,0,1 on consecutive cycles, `sof`=1 on the first bit.
  - Required: after the 8th posedge, `dout`=0xA5 and `dout_vld`=1 for exactly one cycle; `ovf`=0.
- **Gapped input:** same bits as above with `din_vld`=0 between every bit.
  - Required: `dout`=0xA5; `bit_cnt` counts 1..7 and then returns to 0.
- **Backpressure and overflow:** `dout_rdy`=0; send 0x3C, then 0xFF.
  - Required: `dout` stays 0x3C; `ovf`=1 after the 0xFF completes.
  - Then raise `dout_rdy` for one cycle. Required: `dout_vld`=0 and `ovf` stays 1.
- **Simultaneous drain and load:** `dout_rdy`=1 exactly on the cycle 0x12 is consumed while the last bit of 0x34 arrives.
  - Required: `dout`=0x34, `dout_vld` stays 1, `ovf`=0.
- **Resync:** send 3 bits (1,1,1), then `sof`=1 with bits 1,0,0,0,0,0,0,1.
  - Required: `dout`=0x81, `ovf`=0.
- **Reset mid-word, then LSB-first:** assert `rst` after 5 bits.
  - Required: all outputs return to 0.
  - Then, with `MSB_FIRST`=0, send bits 1,0,1,0,0,1,0,1. Required: `dout`=0xA5.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a one-entry valid/ready output
// register and a sticky overflow flag for words dropped under backpressure.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_vld,
    input  logic                     sof,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_vld,
    input  logic                     dout_rdy,
    output logic                     ovf,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             done;
    state_t           state_q, state_d;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sh_q[WIDTH-2:0], din};
        end else begin
            shifted = {din, sh_q[WIDTH-1:1]};
        end
    end

    // A sof bit is always bit 0, so it can never complete a word.
    assign done = din_vld && !sof && (cnt_q == LAST);

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (din_vld) begin
            sh_d = shifted;
            if (sof) begin
                cnt_d = CW'(1);
            end else if (done) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            EMPTY: begin
                if (done) begin
                    dout_d  = shifted;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (dout_rdy) begin
                    if (done) begin
                        dout_d = shifted;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (done) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = (state_q == FULL);
    assign ovf      = ovf_q;
    assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed and random checks of sipo_deser (MSB- and LSB-first instances)
// against a queue-based word assembly model.
module tb_sipo_deser;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_vld = 1'b0;
    logic       sof = 1'b0;
    logic       dout_rdy = 1'b0;

    logic [W-1:0] m_dout, l_dout;
    logic         m_vld, l_vld;
    logic         m_ovf, l_ovf;
    logic [2:0]   m_cnt, l_cnt;

    int ncmp = 0;
    int nfail = 0;

    bit         mq[$];
    logic       mfull = 1'b0;
    logic       movf = 1'b0;
    logic [7:0] mm = '0;
    logic [7:0] ml = '0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
        .dout(m_dout), .dout_vld(m_vld), .dout_rdy(dout_rdy),
        .ovf(m_ovf), .bit_cnt(m_cnt)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
        .dout(l_dout), .dout_vld(l_vld), .dout_rdy(dout_rdy),
        .ovf(l_ovf), .bit_cnt(l_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit b, input bit v, input bit s,
                         input bit r, input bit rs);
        bit         done;
        logic [7:0] wm, wl;
        done = 1'b0;
        wm = '0;
        wl = '0;
        if (rs) begin
            mq.delete();
            mfull = 1'b0;
            movf = 1'b0;
            mm = '0;
            ml = '0;
            return;
        end
        if (v) begin
            if (s) mq.delete();
            mq.push_back(b);
            if (mq.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    wm = wm | (8'(mq[i]) << (W - 1 - i));
                    wl = wl | (8'(mq[i]) << i);
                end
                mq.delete();
            end
        end
        if (!mfull) begin
            if (done) begin
                mm = wm;
                ml = wl;
                mfull = 1'b1;
            end
        end else if (r) begin
            if (done) begin
                mm = wm;
                ml = wl;
            end else begin
                mfull = 1'b0;
            end
        end else if (done) begin
            movf = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("msb_dout", 32'(m_dout), 32'(mm));
        chk("lsb_dout", 32'(l_dout), 32'(ml));
        chk("msb_vld", 32'(m_vld), 32'(mfull));
        chk("lsb_vld", 32'(l_vld), 32'(mfull));
        chk("msb_ovf", 32'(m_ovf), 32'(movf));
        chk("lsb_ovf", 32'(l_ovf), 32'(movf));
        chk("msb_cnt", 32'(m_cnt), 32'(mq.size()));
        chk("lsb_cnt", 32'(l_cnt), 32'(mq.size()));
    endtask

    task automatic step(input bit b, input bit v, input bit s,
                        input bit r, input bit rs);
        din = b;
        din_vld = v;
        sof = s;
        dout_rdy = r;
        rst = rs;
        @(posedge clk);
        model(b, v, s, r, rs);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input bit s,
                             input bit r);
        logic [7:0] t;
        t = w;
        for (int i = 0; i < W; i++) begin
            step(t[7-i], 1'b1, s && (i == 0), r, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        @(negedge clk);

        step(0, 0, 0, 0, 1);
        chk("rst_dout", 32'(m_dout), 32'h0);
        chk("rst_vld", 32'(m_vld), 32'h0);
        chk("rst_ovf", 32'(m_ovf), 32'h0);
        chk("rst_cnt", 32'(m_cnt), 32'h0);

        send_word(8'hA5, 1, 1);
        chk("basic_dout", 32'(m_dout), 32'hA5);
        chk("basic_vld", 32'(m_vld), 32'h1);
        chk("basic_ovf", 32'(m_ovf), 32'h0);
        step(0, 0, 0, 1, 0);
        chk("basic_vld_1cyc", 32'(m_vld), 32'h0);

        for (int i = 0; i < W; i++) begin
            step(a5[7-i], 1, i == 0, 1, 0);
            chk("gap_cnt", 32'(m_cnt), 32'((i + 1) % W));
            step(0, 0, 0, 1, 0);
        end
        chk("gap_dout", 32'(m_dout), 32'hA5);

        send_word(8'h3C, 1, 0);
        send_word(8'hFF, 1, 0);
        chk("bp_dout", 32'(m_dout), 32'h3C);
        chk("bp_ovf", 32'(m_ovf), 32'h1);
        step(0, 0, 0, 1, 0);
        chk("bp_drain_vld", 32'(m_vld), 32'h0);
        chk("bp_ovf_sticky", 32'(m_ovf), 32'h1);

        step(0, 0, 0, 0, 1);
        send_word(8'h12, 1, 0);
        for (int i = 0; i < W; i++) begin
            logic [7:0] t;
            t = 8'h34;
            step(t[7-i], 1, i == 0, i == W - 1, 0);
        end
        chk("sim_dout", 32'(m_dout), 32'h34);
        chk("sim_vld", 32'(m_vld), 32'h1);
        chk("sim_ovf", 32'(m_ovf), 32'h0);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0);
        send_word(8'h81, 1, 1);
        chk("resync_dout", 32'(m_dout), 32'h81);
        chk("resync_ovf", 32'(m_ovf), 32'h0);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 5; i++) step(a5[7-i], 1, i == 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("midrst_dout", 32'(m_dout), 32'h0);
        chk("midrst_vld", 32'(m_vld), 32'h0);
        chk("midrst_cnt", 32'(m_cnt), 32'h0);
        chk("midrst_lcnt", 32'(l_cnt), 32'h0);
        send_word(8'hA5, 1, 1);
        chk("lsb_a5", 32'(l_dout), 32'hA5);
        chk("lsb_a5_vld", 32'(l_vld), 32'h1);

        step(0, 0, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom), $urandom_range(3) != 0,
                 $urandom_range(9) == 0, 1'($urandom),
                 $urandom_range(99) == 0);
        end

        step(0, 0, 0, 0, 1);
        for (int n = 0; n < 20 * W; n++) begin
            step(1'($urandom), 1, 1'b0, 1, 0);
        end
        chk("thru_ovf", 32'(m_ovf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
